// File: rtl/pe_pkg.sv
// pe_pkg: shared types and default sizing for the systolic processing element.
//   pe_state_t  : PE control state (IDLE / ACCUM / HOLD)
//   *_DEF       : default DATA_W / ACC_W / K_LEN used by systolic_pe
package pe_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 40;
    localparam int K_LEN_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // count = 0, acc = 0
        ACCUM = 2'd1,   // partial sum live
        HOLD  = 2'd2    // completed result blocked by the consumer
    } pe_state_t;

endpackage

// File: rtl/sat_add.sv
// sat_add: W-bit signed adder with signed-overflow detection.
//   a, b : signed addends
//   sum  : a + b, wrapped two's-complement, or clamped to the W-bit range
//          when SYSTOLIC_PE_SAT_EN is defined
//   ovf  : the true sum does not fit in W signed bits
// Macro: SYSTOLIC_PE_SAT_EN selects clamping instead of wrapping.
module sat_add #(
    parameter int W = 40
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    logic signed [W-1:0] raw;

    assign raw = a + b;
    // Overflow only possible when both addends share a sign and the result flips it.
    assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef SYSTOLIC_PE_SAT_EN
    function automatic logic signed [W-1:0] sat_value(input logic neg);
        return neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    endfunction

    // On overflow the direction is given by the common sign of the addends.
    assign sum = ovf ? sat_value(a[W-1]) : raw;
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/systolic_pe.sv
// systolic_pe: output-stationary systolic PE. Multiplies a_in*b_in, sums
// K_LEN consecutive products and presents the dot product on c_out.
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   clear               : synchronous abort of the current partial sum
//   in_valid/in_ready   : operand handshake for a_in/b_in
//   a_out/b_out/ab_valid: registered operand forward to east/south neighbours
//   c_out/c_valid/c_ready: result handshake
//   overflow            : sticky signed accumulation overflow
// Pipeline: S1 registers the product (+valid/last), S2 accumulates.
// Macro: SYSTOLIC_PE_SAT_EN (in sat_add) clamps overflowing adds.
module systolic_pe
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int K_LEN  = K_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic signed [DATA_W-1:0] b_out,
    output logic                     ab_valid,
    output logic signed [ACC_W-1:0]  c_out,
    output logic                     c_valid,
    input  logic                     c_ready,
    output logic                     overflow
);

    localparam int CNT_W = (K_LEN > 1) ? $clog2(K_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN - 1);

    logic                       ready_en;
    logic [CNT_W-1:0]           count;
    logic [CNT_W-1:0]           count_nxt;
    logic signed [2*DATA_W-1:0] prod_full;
    logic signed [ACC_W-1:0]    prod_p1;
    logic                       vld_p1;
    logic                       last_p1;
    logic signed [ACC_W-1:0]    acc_p2;
    logic signed [ACC_W-1:0]    sum;
    logic                       add_ovf;
    logic                       accept;
    logic                       stall;
    logic                       absorb;
    logic                       is_last;
    pe_state_t                  state;
    pe_state_t                  state_nxt;

    // A last product cannot leave S1 while the previous result is still unconsumed.
    assign stall    = vld_p1 && last_p1 && c_valid && !c_ready;
    // ready_en keeps in_ready low during reset and rises on the first edge after it.
    assign in_ready = ready_en && !clear && !stall;
    assign accept   = in_valid && in_ready;
    assign is_last  = (count == CNT_LAST);
    assign absorb   = vld_p1 && !stall && !clear;

    assign prod_full = (2*DATA_W)'(a_in) * (2*DATA_W)'(b_in);

    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (accept) begin
            count_nxt = is_last ? '0 : count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && (K_LEN > 1)) state_nxt = ACCUM;
            ACCUM:   if (absorb && last_p1 && (count_nxt == '0)) state_nxt = IDLE;
            HOLD:    if (!stall) state_nxt = (count_nxt != '0) ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (stall) state_nxt = HOLD;
        if (clear) state_nxt = IDLE;
    end

    sat_add #(.W(ACC_W)) u_sat_add (
        .a   (acc_p2),
        .b   (prod_p1),
        .sum (sum),
        .ovf (add_ovf)
    );

    // S1 product data: only meaningful while vld_p1 is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            prod_p1 <= ACC_W'(prod_full);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en <= 1'b0;
            count    <= '0;
            state    <= IDLE;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            a_out    <= '0;
            b_out    <= '0;
            ab_valid <= 1'b0;
            acc_p2   <= '0;
            c_out    <= '0;
            c_valid  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            count    <= count_nxt;
            state    <= state_nxt;

            // ---- S1: operand capture / neighbour forward ----
            ab_valid <= accept;
            if (accept) begin
                a_out   <= a_in;
                b_out   <= b_in;
                last_p1 <= is_last;
            end
            if (clear) begin
                vld_p1 <= 1'b0;
            end else if (!stall) begin
                vld_p1 <= accept;
            end

            // ---- S2: accumulate / complete ----
            if (clear) begin
                acc_p2   <= '0;
                overflow <= 1'b0;
            end else if (absorb) begin
                if (add_ovf) overflow <= 1'b1;
                if (last_p1) begin
                    c_out  <= sum;
                    acc_p2 <= '0;
                end else begin
                    acc_p2 <= sum;
                end
            end

            // A fresh result takes priority so a consume+load edge leaves no bubble.
            if (absorb && last_p1) begin
                c_valid <= 1'b1;
            end else if (c_ready) begin
                c_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_systolic_pe.sv
module tb_systolic_pe;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int KL = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] a_in;
    logic signed [DW-1:0] b_in;
    logic signed [DW-1:0] a_out;
    logic signed [DW-1:0] b_out;
    logic                 ab_valid;
    logic signed [AW-1:0] c_out;
    logic                 c_valid;
    logic                 c_ready;
    logic                 overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic signed [AW-1:0] exp_q[$];

    typedef struct {
        int a[4];
        int b[4];
        int c;
    } vec_t;

    vec_t vecs[5];

    systolic_pe #(.DATA_W(DW), .ACC_W(AW), .K_LEN(KL)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .a_out    (a_out),
        .b_out    (b_out),
        .ab_valid (ab_valid),
        .c_out    (c_out),
        .c_valid  (c_valid),
        .c_ready  (c_ready),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic signed [63:0] act, logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Scoreboard: a result is consumed on the coming edge when c_valid && c_ready.
    always @(negedge clk) begin
        if (!reset && c_valid && c_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL c_out_unexpected: got %0d, expected no result", c_out);
            end else begin
                check("c_out", c_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input int a, input int b);
        int waits;
        waits    = 0;
        in_valid = 1'b1;
        a_in     = DW'(a);
        b_in     = DW'(b);
        #1;
        while (!in_ready && waits < 50) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            check("send_in_ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int t0;
        logic signed [AW-1:0] ovf_exp;

        vecs[0] = '{a: '{3, 3, 3, 3},          b: '{4, 4, 4, 4},          c: 48};
        vecs[1] = '{a: '{-5, 2, -1, 0},        b: '{7, 3, -1, 9},         c: -28};
        vecs[2] = '{a: '{-100, 7, 1000, -3},   b: '{50, -8, 1000, -3},    c: 994953};
        vecs[3] = '{a: '{0, 0, 0, 0},          b: '{123, -456, 789, -1},  c: 0};
        vecs[4] = '{a: '{-32768, -32768, 32767, 1}, b: '{1, 1, 1, -1},    c: -32770};

        reset    = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        c_ready  = 1'b1;

        // Reset state
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_ab_valid", ab_valid, 0);
        check("rst_c_valid", c_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_c_out", c_out, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rel_in_ready_low", in_ready, 0);
        idle(1);
        check("rel_in_ready_high", in_ready, 1);

        // Basic group with latency and neighbour-forward checks
        exp_q.push_back(48);
        for (int i = 0; i < 4; i++) send(3, 4);
        check("fwd_ab_valid", ab_valid, 1);
        check("fwd_a_out", a_out, 3);
        check("fwd_b_out", b_out, 4);
        check("lat_t1_c_valid", c_valid, 0);
        idle(1);
        check("lat_t2_c_valid", c_valid, 1);
        check("lat_t2_c_out", c_out, 48);
        check("fwd_ab_valid_idle", ab_valid, 0);
        idle(2);

        // Table-driven groups, back to back
        t0 = cyc;
        foreach (vecs[v]) begin
            exp_q.push_back(vecs[v].c);
            for (int i = 0; i < 4; i++) send(vecs[v].a[i], vecs[v].b[i]);
        end
        check("table_throughput_cycles", cyc - t0, 20);
        idle(3);
        check("table_overflow", overflow, 0);

        // Backpressure: two groups with the consumer stalled
        c_ready = 1'b0;
        exp_q.push_back(4);
        exp_q.push_back(4);
        for (int i = 0; i < 8; i++) send(1, 1);
        check("bp_in_ready_stall", in_ready, 0);
        check("bp_c_valid_held", c_valid, 1);
        check("bp_c_out_held", c_out, 4);
        idle(3);
        check("bp_in_ready_still", in_ready, 0);
        check("bp_c_valid_still", c_valid, 1);
        c_ready = 1'b1;
        idle(1);
        check("bp_no_bubble_c_valid", c_valid, 1);
        check("bp_second_c_out", c_out, 4);
        idle(1);
        check("bp_no_dup_c_valid", c_valid, 0);
        check("bp_in_ready_back", in_ready, 1);

        // Overflow
`ifdef SYSTOLIC_PE_SAT_EN
        ovf_exp = 32'sh7FFFFFFF;
`else
        ovf_exp = 32'sh00000000;
`endif
        exp_q.push_back(ovf_exp);
        for (int i = 0; i < 4; i++) send(-32768, -32768);
        idle(2);
        check("ovf_flag", overflow, 1);
        idle(2);
        check("ovf_sticky", overflow, 1);

        // Clear with a simultaneous offered pair
        for (int i = 0; i < 3; i++) send(2, 2);
        clear    = 1'b1;
        in_valid = 1'b1;
        a_in     = 16'sd7;
        b_in     = 16'sd7;
        #1;
        check("clr_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_ab_valid", ab_valid, 0);
        check("clr_a_out", a_out, 2);
        check("clr_overflow", overflow, 0);
        exp_q.push_back(4);
        for (int i = 0; i < 4; i++) send(1, 1);
        idle(3);

        // Reset mid-group
        for (int i = 0; i < 2; i++) send(5, 5);
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_a_out", a_out, 0);
        check("mid_rst_b_out", b_out, 0);
        check("mid_rst_c_out", c_out, 0);
        check("mid_rst_c_valid", c_valid, 0);
        check("mid_rst_ab_valid", ab_valid, 0);
        check("mid_rst_overflow", overflow, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        check("mid_rel_in_ready", in_ready, 1);
        exp_q.push_back(8);
        for (int i = 0; i < 4; i++) send(1, 2);
        idle(3);
        check("post_rst_c_out", c_out, 8);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
